// File: rtl/bb_pkg.sv
// Shared BCD types and helpers for the breakout-board counter and its debouncer.
package bb_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef struct packed {
    logic carry;
    bcd_t digit;
  } bcd_step_t;

  typedef enum logic {
    DB_RELEASED,
    DB_PRESSED
  } deb_state_t;

  // One BCD digit stepped up or down; carry doubles as borrow when counting down.
  function automatic bcd_step_t bcd_step(input bcd_t d, input logic down, input logic en);
    bcd_step_t r;
    r.carry = 1'b0;
    r.digit = d;
    if (en) begin
      if (down) begin
        if (d == '0) begin
          r.carry = 1'b1;
          r.digit = BCD_MAX;
        end else begin
          r.digit = d - 1'b1;
        end
      end else begin
        if (d >= BCD_MAX) begin
          r.carry = 1'b1;
          r.digit = '0;
        end else begin
          r.digit = d + 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_t bcd_sanitize(input bcd_t n);
    return (n > BCD_MAX) ? '0 : n;
  endfunction

endpackage

// File: rtl/bb_debounce.sv
// Pushbutton synchroniser and debouncer; emits a one-clk pulse on an accepted press.
module bb_debounce
  import bb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CLKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic pressed,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CLKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CLKS - 1);

  logic           sync1_q, sync2_q;
  deb_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           acc_level;
  logic           differ;
  logic           accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= DB_RELEASED;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accepted level is encoded in the state: released means btn_n is high.
  always_comb begin
    acc_level = (state_q == DB_RELEASED);
    differ    = (sync2_q != acc_level);
    accept    = differ && (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (state_q == DB_RELEASED) ? DB_PRESSED : DB_RELEASED;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (differ && !accept) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    pressed = accept && (state_q == DB_RELEASED);
    level   = acc_level;
  end

endmodule

// File: rtl/bb_bcd3_counter.sv
// Three-digit BCD up/down counter with prescaler, parallel load, run/pause button
// and display helper flags for the LCD digit decoders.
module bb_bcd3_counter
  import bb_pkg::*;
#(
  parameter int unsigned PRESCALE      = 2048,
  parameter int unsigned DEBOUNCE_CLKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir,
  input  logic             load,
  input  logic [11:0]      load_val,
  input  logic             btn_n,
  output logic [BCD_W-1:0] dig0,
  output logic [BCD_W-1:0] dig1,
  output logic [BCD_W-1:0] dig2,
  output logic             wrap,
  output logic             blank2,
  output logic             blank1,
  output logic             running
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  bcd_t          dig0_q, dig0_d;
  bcd_t          dig1_q, dig1_d;
  bcd_t          dig2_q, dig2_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          wrap_q, wrap_d;
  logic          running_q, running_d;
  logic          step_due;
  logic          btn_pressed;
  logic          unused_btn_level;
  bcd_step_t     s0, s1, s2;

  bb_debounce #(
    .DEBOUNCE_CLKS(DEBOUNCE_CLKS)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .raw_n  (btn_n),
    .pressed(btn_pressed),
    .level  (unused_btn_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig0_q    <= '0;
      dig1_q    <= '0;
      dig2_q    <= '0;
      presc_q   <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b1;
    end else begin
      dig0_q    <= dig0_d;
      dig1_q    <= dig1_d;
      dig2_q    <= dig2_d;
      presc_q   <= presc_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  // Step decision uses running_q, so a press landing on a step edge does not cancel it.
  always_comb begin
    step_due = running_q && (presc_q == PRESC_LAST);
    s0 = bcd_step(dig0_q, dir, 1'b1);
    s1 = bcd_step(dig1_q, dir, s0.carry);
    s2 = bcd_step(dig2_q, dir, s1.carry);
  end

  always_comb begin
    dig0_d    = dig0_q;
    dig1_d    = dig1_q;
    dig2_d    = dig2_q;
    presc_d   = presc_q;
    wrap_d    = 1'b0;
    running_d = running_q ^ btn_pressed;
    if (load) begin
      dig0_d  = bcd_sanitize(load_val[3:0]);
      dig1_d  = bcd_sanitize(load_val[7:4]);
      dig2_d  = bcd_sanitize(load_val[11:8]);
      presc_d = '0;
    end else if (running_q) begin
      if (step_due) begin
        presc_d = '0;
        dig0_d  = s0.digit;
        dig1_d  = s1.digit;
        dig2_d  = s2.digit;
        wrap_d  = s2.carry;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    dig0    = dig0_q;
    dig1    = dig1_q;
    dig2    = dig2_q;
    wrap    = wrap_q;
    running = running_q;
    blank2  = (dig2_q == '0);
    blank1  = (dig2_q == '0) && (dig1_q == '0);
  end

endmodule

// File: tb/tb_bb_bcd3_counter.sv
// Directed scoreboard bench for bb_bcd3_counter with PRESCALE=4, DEBOUNCE_CLKS=3.
module tb_bb_bcd3_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dir;
  logic        load;
  logic [11:0] load_val;
  logic        btn_n;
  logic [3:0]  dig0, dig1, dig2;
  logic        wrap, blank2, blank1, running;
  logic [15:0] obs;

  int n_total = 0;
  int n_pass  = 0;
  int wraps;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } sb_t;

  sb_t sb[$];

  bb_bcd3_counter #(
    .PRESCALE     (4),
    .DEBOUNCE_CLKS(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .btn_n   (btn_n),
    .dig0    (dig0),
    .dig1    (dig1),
    .dig2    (dig2),
    .wrap    (wrap),
    .blank2  (blank2),
    .blank1  (blank1),
    .running (running)
  );

  always #5 clk = ~clk;

  assign obs = {dig2, dig1, dig0, wrap, blank2, blank1, running};

  // Expected observation: digits, wrap, derived blank flags, running.
  function automatic logic [15:0] ex(input logic [11:0] d, input logic w, input logic r);
    return {d, w, (d[11:8] == 4'd0), (d[11:4] == 8'd0), r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input int n, input logic [15:0] e);
    sb_t x;
    sb.push_back('{tag, e});
    repeat (n) tick();
    x = sb.pop_front();
    n_total++;
    assert (obs === x.val) n_pass++;
    else $error("FAIL %s: got %h expected %h", x.tag, obs, x.val);
  endtask

  initial begin
    rst      = 1'b1;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    btn_n    = 1'b1;
    #2;
    step_chk("reset", 0, ex(12'h000, 1'b0, 1'b1));
    repeat (2) tick();
    rst = 1'b0;

    step_chk("pre_step", 3, ex(12'h000, 1'b0, 1'b1));
    step_chk("first_step", 1, ex(12'h001, 1'b0, 1'b1));
    step_chk("up_009", 32, ex(12'h009, 1'b0, 1'b1));
    step_chk("up_010", 4, ex(12'h010, 1'b0, 1'b1));

    load = 1'b1; load_val = 12'h998;
    step_chk("load_998", 1, ex(12'h998, 1'b0, 1'b1));
    load = 1'b0;
    wraps = 0;
    repeat (8) begin
      tick();
      wraps += int'(wrap);
    end
    n_total++;
    assert (wraps == 1) n_pass++;
    else $error("FAIL wrap_count_up: got %0d expected 1", wraps);
    step_chk("wrap_up", 0, ex(12'h000, 1'b1, 1'b1));
    step_chk("wrap_up_clr", 1, ex(12'h000, 1'b0, 1'b1));

    dir = 1'b1;
    load = 1'b1; load_val = 12'h001;
    step_chk("load_001", 1, ex(12'h001, 1'b0, 1'b1));
    load = 1'b0;
    step_chk("down_000", 4, ex(12'h000, 1'b0, 1'b1));
    step_chk("wrap_dn", 4, ex(12'h999, 1'b1, 1'b1));
    step_chk("wrap_dn_clr", 1, ex(12'h999, 1'b0, 1'b1));
    load = 1'b1; load_val = 12'h100;
    step_chk("load_100", 1, ex(12'h100, 1'b0, 1'b1));
    load = 1'b0;
    step_chk("borrow_099", 4, ex(12'h099, 1'b0, 1'b1));

    dir = 1'b0;
    load = 1'b1; load_val = 12'hA5F;
    step_chk("load_sanit", 1, ex(12'h050, 1'b0, 1'b1));
    load = 1'b0;
    step_chk("load_nostep", 3, ex(12'h050, 1'b0, 1'b1));
    step_chk("load_step", 1, ex(12'h051, 1'b0, 1'b1));
    tick(); tick(); tick();
    load = 1'b1; load_val = 12'h123;
    step_chk("load_prio", 1, ex(12'h123, 1'b0, 1'b1));
    load = 1'b0;
    step_chk("prio_hold", 3, ex(12'h123, 1'b0, 1'b1));
    step_chk("prio_step", 1, ex(12'h124, 1'b0, 1'b1));

    btn_n = 1'b0;
    tick(); tick();
    btn_n = 1'b1;
    step_chk("glitch", 4, ex(12'h125, 1'b0, 1'b1));
    btn_n = 1'b0;
    step_chk("press_pause", 6, ex(12'h126, 1'b0, 1'b0));
    btn_n = 1'b1;
    step_chk("frozen", 20, ex(12'h126, 1'b0, 1'b0));
    btn_n = 1'b0;
    step_chk("press_resume", 6, ex(12'h127, 1'b0, 1'b1));
    btn_n = 1'b1;
    step_chk("resumed", 10, ex(12'h129, 1'b0, 1'b1));

    load = 1'b1; load_val = 12'h537;
    step_chk("load_537", 1, ex(12'h537, 1'b0, 1'b1));
    load = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    step_chk("rst_async", 0, ex(12'h000, 1'b0, 1'b1));
    tick(); tick();
    rst = 1'b0;
    step_chk("rst_nostep", 3, ex(12'h000, 1'b0, 1'b1));
    step_chk("rst_step", 1, ex(12'h001, 1'b0, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bb_bcd3_counter.md
Name: bb_bcd3_counter

Overview:
Three-digit cascaded BCD counter (000-999) that produces the digit values for the breakout-board LCD path; its outputs feed the per-digit BCD-to-7-segment decoders directly. It runs on the slow board clock, has an internal prescaler, and supports up/down counting and parallel BCD load. A debounced pushbutton toggles run/pause. It also supplies a one-cycle wrap pulse and leading-zero blank flags for the display stage.

Parameters:
PRESCALE, 2048, number of clk cycles per count step while running (min 1).
DEBOUNCE_CLKS, 16, consecutive stable synchronised samples required to accept a button level (min 2).

Ports:
clk  input  1  board slow clock (5 kHz osc timer output); all logic rising-edge.
rst  input  1  asynchronous, active-high reset.
dir  input  1  0 = count up, 1 = count down; sampled on each step.
load  input  1  synchronous parallel load strobe, level-sampled each clk.
load_val  input  12  BCD load value {hundreds, tens, units}, 4 bits each.
btn_n  input  1  raw pushbutton, active-low, asynchronous to clk, bouncy.
dig0  output  4  units digit, BCD 0-9.
dig1  output  4  tens digit, BCD 0-9.
dig2  output  4  hundreds digit, BCD 0-9.
wrap  output  1  one-clk pulse on 999->000 (up) or 000->999 (down).
blank2  output  1  1 when dig2 == 0 (leading zero).
blank1  output  1  1 when dig2 == 0 and dig1 == 0.
running  output  1  1 = counting enabled, 0 = paused.

Behaviour:
- Reset (async, immediate): digits 0/0/0, prescaler 0, wrap 0, running 1, debouncer state = released, sync flops 1. Resulting blank2 = 1 and blank1 = 1. Reset asserted mid-operation clears everything in the same instant, with no partial update.
- Prescaler counts 0..PRESCALE-1 only while running. The step fires on the clk edge where the prescaler equals PRESCALE-1, and the prescaler returns to 0. While paused, the prescaler holds its value. With PRESCALE=1, a step fires on every running clk.
- Step, up: units +1. On 9 the units digit goes to 0 and carries into tens, and likewise from tens into hundreds. 999 becomes 000 with wrap=1 for that one clk.
- Step, down: mirror behaviour. A digit at 0 goes to 9 and borrows from the next digit. 000 becomes 999 with wrap=1.
- wrap is registered and is high for exactly one clk after the wrapping edge; otherwise it is 0.
- load: highest priority. Digits take load_val on that edge, the prescaler clears to 0, wrap=0, and no step occurs that cycle even if one was due. Any load nibble >9 is loaded as 0 for that digit only. load does not affect running.
- Digits never leave the range 0-9 by any path.
- blank1/blank2 are combinational from the registered digits. dig0 is never blanked.
- Debouncer: btn_n passes through 2 flops to synchronise it. A counter runs while the synchronised level differs from the accepted level and clears when they match. When the count reaches DEBOUNCE_CLKS, the accepted level updates.
- Running toggles only on an accepted 1->0 transition (press). Release and bounces shorter than DEBOUNCE_CLKS have no effect.
- Toggle and load arriving on the same clk: both take effect. Toggle and a step on the same clk: the step uses the pre-toggle running value.
- dir changing between steps is legal. Each step uses the dir value present on its edge.

Decomposition:
- Shared package (bb_pkg): BCD digit width 4, BCD_MAX 4'd9, a digit-increment/decrement-with-carry function, and the load sanitise rule.
- One sub-module: bb_debounce (clk, rst, raw_n, pressed pulse, level). It holds the 2-flop synchroniser and the stability counter.
- The counter and prescaler stay in the parent.

Test Plan:
All scenarios use bench parameters PRESCALE=4 and DEBOUNCE_CLKS=3.
- Reset then run up for 40 clks: digits step every 4 clks, 000->010 after 40 clks. blank2=1 throughout; blank1 drops when dig1 becomes 1.
- Load 12'h998 with dir=0: after 8 clks the digits read 000 and wrap pulses exactly once, for 1 clk, on the 998->999->000 second step.
- Load 12'h001 with dir=1: after 8 clks the digits read 999, wrap is 1 for one clk, and blank1=blank2=0.
- Load 12'hA5F: the digits load as 0/5/0. The prescaler restarts, so the first step comes 4 clks after the load.
- btn_n glitches low for 2 clks, then is held low for 6 clks: only the held press toggles running (1->0), and the digits freeze while the prescaler holds. A second clean press resumes counting from the held value.
- Assert rst mid-count while digits=537 and the prescaler=2: outputs go immediately to 000, running=1 and wrap=0. The first step comes 4 clks after rst deasserts.
